// File: rtl/cnn_frame_loader.sv
// rtl/cnn_frame_loader.sv - pixel-stream frame loader and Lenet run/result sequencer.
// Optional FRAME_CNT_EN adds a 16-bit count of delivered results (frame_count).
module cnn_frame_loader #(
  parameter int PIX_W          = 16,
  parameter int IMG_PIX        = 1024,
  parameter int COMPUTE_CYCLES = 75720
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_valid,
  input  logic [PIX_W-1:0]         s_data,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic [PIX_W*IMG_PIX-1:0] cnn_input,
  output logic                     cnn_reset,
  input  logic [3:0]               lenet_output,
  output logic                     result_valid,
  output logic [3:0]               result_label,
  input  logic                     result_ready,
  output logic                     frame_err
`ifdef FRAME_CNT_EN
  ,
  output logic [15:0]              frame_count
`endif
);

  localparam int PW = $clog2(IMG_PIX);
  localparam int RW = $clog2(COMPUTE_CYCLES);
  localparam int BW = $clog2(PIX_W * IMG_PIX);
  localparam logic [PW-1:0] PIX_LAST = PW'(IMG_PIX - 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(COMPUTE_CYCLES - 1);

  typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;

  state_t                     state_q, state_d;
  logic [PW-1:0]              pix_cnt_q, pix_cnt_d;
  logic [RW-1:0]              run_cnt_q, run_cnt_d;
  logic                       result_valid_q, result_valid_d;
  logic [3:0]                 result_label_q, result_label_d;
  logic                       frame_err_q, frame_err_d;
  logic [PIX_W*IMG_PIX-1:0]   cnn_input_q;
  logic [BW-1:0]              wr_base;

  logic beat, pix_end, run_end, handshake;

  assign beat      = s_valid && s_ready;
  assign pix_end   = (pix_cnt_q == PIX_LAST);
  assign run_end   = (state_q == RUN) && (run_cnt_q == RUN_LAST);
  assign handshake = (state_q == DONE) && result_valid_q && result_ready;
  // First accepted pixel occupies the top slot so the vector reads in stream order.
  assign wr_base   = BW'(PIX_LAST - pix_cnt_q) * BW'(PIX_W);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (beat && pix_end) state_d = RUN;
      RUN:     if (run_end)         state_d = DONE;
      DONE:    if (handshake)       state_d = LOAD;
      default:                      state_d = LOAD;
    endcase
  end

  // s_ready is gated by reset so nothing is accepted while reset is held.
  always_comb begin
    s_ready   = reset && (state_q == LOAD);
    cnn_reset = (state_q != RUN);
  end

  always_comb begin
    pix_cnt_d      = pix_cnt_q;
    run_cnt_d      = run_cnt_q;
    result_valid_d = result_valid_q;
    result_label_d = result_label_q;
    frame_err_d    = beat && (s_last != pix_end);
    if (handshake) begin
      pix_cnt_d      = '0;
      run_cnt_d      = '0;
      result_valid_d = 1'b0;
    end else if (beat) begin
      if (s_last && !pix_end) pix_cnt_d = '0;
      else if (!pix_end)      pix_cnt_d = pix_cnt_q + 1'b1;
    end
    if (run_end) begin
      result_valid_d = 1'b1;
      result_label_d = lenet_output;
    end else if (state_q == RUN) begin
      run_cnt_d = run_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_cnt_q      <= '0;
      run_cnt_q      <= '0;
      result_valid_q <= 1'b0;
      result_label_q <= '0;
      frame_err_q    <= 1'b0;
      cnn_input_q    <= '0;
    end else begin
      pix_cnt_q      <= pix_cnt_d;
      run_cnt_q      <= run_cnt_d;
      result_valid_q <= result_valid_d;
      result_label_q <= result_label_d;
      frame_err_q    <= frame_err_d;
      if (beat) cnn_input_q[wr_base +: PIX_W] <= s_data;
    end
  end

`ifdef FRAME_CNT_EN
  logic [15:0] frame_count_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         frame_count_q <= '0;
    else if (handshake) frame_count_q <= frame_count_q + 16'd1;
  end
  assign frame_count = frame_count_q;
`endif

  assign cnn_input    = cnn_input_q;
  assign result_valid = result_valid_q;
  assign result_label = result_label_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_cnn_frame_loader.sv
// tb/tb_cnn_frame_loader.sv - table-driven frame vectors plus abort/reset sequences with a label scoreboard.
module tb_cnn_frame_loader;
  localparam int PIX_W = 16;
  localparam int IMG_PIX = 1024;
  localparam int CC = 8;
  localparam int VW = PIX_W * IMG_PIX;

  logic clk, reset, s_valid, s_last, s_ready, cnn_reset;
  logic [PIX_W-1:0] s_data;
  logic [VW-1:0] cnn_input;
  logic [3:0] lenet_output, result_label;
  logic result_valid, result_ready, frame_err;
`ifdef FRAME_CNT_EN
  logic [15:0] frame_count;
`endif

  cnn_frame_loader #(.PIX_W(PIX_W), .IMG_PIX(IMG_PIX), .COMPUTE_CYCLES(CC)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .cnn_input(cnn_input), .cnn_reset(cnn_reset),
    .lenet_output(lenet_output), .result_valid(result_valid), .result_label(result_label),
    .result_ready(result_ready), .frame_err(frame_err)
`ifdef FRAME_CNT_EN
    , .frame_count(frame_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] base;
    logic [3:0]  label;
    bit          drop_last;
    bit          rnd;
    int          hold;
    logic [15:0] exp_first;
    logic [15:0] exp_last;
    int          exp_err;
  } vec_t;

  vec_t vecs[3];
  logic [3:0] exp_q[$];
  int n_cmp = 0, n_bad = 0;
  int err_seen, err_bad;
  bit prev_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic note_err();
    if (frame_err) err_seen++;
    if (frame_err !== prev_err) err_bad++;
    prev_err = 1'b0;
  endtask

  task automatic send_beats(input logic [15:0] base, input int n, input int last_at, input bit rnd);
    int k = 0;
    int guard = 0;
    while (k < n && guard < 20000) begin
      @(negedge clk);
      guard++;
      note_err();
      s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = 16'(base + k);
      s_last  = (k == last_at);
      if (s_valid && s_ready) begin
        prev_err = (k == last_at) != (k == IMG_PIX - 1);
        k++;
      end
    end
    if (k < n) check("send_timeout", k, n);
  endtask

  task automatic run_phase(output int low, output int at);
    low = 0;
    at = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      note_err();
      s_valid = 1'b0;
      s_last = 1'b0;
      if (!cnn_reset) low++;
      if (result_valid) begin
        at = n;
        break;
      end
    end
  endtask

  task automatic drain(input int hold);
    int bad = 0;
    logic [3:0] got, exp;
    got = result_label;
    lenet_output = ~lenet_output;
    for (int i = 0; i < hold; i++) begin
      s_valid = 1'b1;
      @(negedge clk);
      if (!result_valid || s_ready || result_label !== got || cnn_reset !== 1'b1) bad++;
    end
    check("done_hold_stable", bad, 0);
    s_valid = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check("post_hs_valid", result_valid, 0);
    check("post_hs_ready", s_ready, 1);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      exp = exp_q.pop_front();
      check("result_label", got, exp);
    end
  endtask

  task automatic run_frame(input vec_t v);
    int low, at;
    lenet_output = v.label;
    exp_q.push_back(v.label);
    err_seen = 0;
    err_bad = 0;
    send_beats(v.base, IMG_PIX, v.drop_last ? -1 : IMG_PIX - 1, v.rnd);
    run_phase(low, at);
    check("run_low_cycles", low, CC);
    check("valid_latency", at, CC + 1);
    check("slot_first", cnn_input[VW-1 -: 16], v.exp_first);
    check("slot_last", cnn_input[15:0], v.exp_last);
    check("slot_mid", cnn_input[(IMG_PIX-1-100)*PIX_W +: 16], 16'(v.exp_first + 100));
    drain(v.hold);
    check("frame_err_count", err_seen, v.exp_err);
    check("frame_err_align", err_bad, 0);
  endtask

  initial begin
    vecs[0] = '{base: 16'h0000, label: 4'd7,  drop_last: 0, rnd: 0, hold: 20,
                exp_first: 16'h0000, exp_last: 16'h03FF, exp_err: 0};
    vecs[1] = '{base: 16'h2000, label: 4'd3,  drop_last: 1, rnd: 1, hold: 0,
                exp_first: 16'h2000, exp_last: 16'h23FF, exp_err: 1};
    vecs[2] = '{base: 16'hFC00, label: 4'd15, drop_last: 0, rnd: 1, hold: 3,
                exp_first: 16'hFC00, exp_last: 16'hFFFF, exp_err: 0};

    reset = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    lenet_output = '0; result_ready = 1'b0; prev_err = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_cnn_reset", cnn_reset, 1);
    check("rst_result_valid", result_valid, 0);
    check("rst_result_label", result_label, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_cnn_input_zero", 32'(cnn_input == '0), 1);
    reset = 1'b1;
    @(negedge clk);
    check("load_s_ready", s_ready, 1);

    foreach (vecs[i]) run_frame(vecs[i]);

    // Early s_last aborts the partial frame; the following full frame must start at slot 0.
    err_seen = 0; err_bad = 0;
    send_beats(16'h5000, 501, 500, 0);
    @(negedge clk);
    note_err();
    s_valid = 1'b0; s_last = 1'b0;
    check("abort_still_load", s_ready, 1);
    check("abort_cnn_reset", cnn_reset, 1);
    @(negedge clk);
    note_err();
    check("abort_err_count", err_seen, 1);
    check("abort_err_align", err_bad, 0);
    run_frame('{base: 16'h1000, label: 4'd9, drop_last: 0, rnd: 0, hold: 1,
                exp_first: 16'h1000, exp_last: 16'h13FF, exp_err: 0});

    // Reset in the middle of the compute window.
    lenet_output = 4'd5;
    send_beats(16'h3000, IMG_PIX, IMG_PIX - 1, 0);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      s_valid = 1'b0; s_last = 1'b0;
    end
    check("pre_rst_running", cnn_reset, 0);
    #1 reset = 1'b0;
    #1;
    check("midrst_cnn_reset", cnn_reset, 1);
    check("midrst_result_valid", result_valid, 0);
    check("midrst_cnn_input_zero", 32'(cnn_input == '0), 1);
    check("midrst_s_ready", s_ready, 0);
    @(negedge clk);
    reset = 1'b1;
    prev_err = 1'b0;
    @(negedge clk);
    check("post_rst_s_ready", s_ready, 1);
    check("post_rst_valid", result_valid, 0);
    check("post_rst_frame_err", frame_err, 0);
`ifdef FRAME_CNT_EN
    check("frame_count_zero", frame_count, 0);
`endif

    for (int i = 0; i < 3; i++)
      run_frame('{base: 16'(16'h4000 + 16'(i) * 16'h0400), label: 4'(i + 1), drop_last: 0, rnd: 0,
                  hold: 0, exp_first: 16'(16'h4000 + 16'(i) * 16'h0400),
                  exp_last: 16'(16'h43FF + 16'(i) * 16'h0400), exp_err: 0});
`ifdef FRAME_CNT_EN
    check("frame_count_three", frame_count, 3);
`endif
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
